lcd_cmd_sequencer: RTL
======================

# lcd_cmd_sequencer

Command sequencer in front of the 8x8 image-display controller. Host logic pushes 4-bit display commands into an internal FIFO. The sequencer issues them one at a time on the controller's cmd/cmd_valid port, and only when the controller reports not-busy. After issuing the Write command (0) it waits for the controller's done and then stops.

## Interface
- DEPTH, 8, FIFO depth in entries; power of two, at least 2.
- AW, 3, FIFO pointer width, log2(DEPTH).

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- push  input  1  host write strobe
- push_cmd  input  4  command code written when push is accepted
- full  output  1  FIFO holds DEPTH entries
- level  output  AW+1  FIFO occupancy, 0..DEPTH
- overflow  output  1  sticky; set by push while full
- bad_cmd  output  1  sticky; set when a code 13..15 is popped
- lcd_busy  input  1  controller busy flag
- lcd_done  input  1  controller done flag
- lcd_cmd  output  4  command to controller; registered
- lcd_cmd_valid  output  1  one-cycle issue strobe; registered
- seq_idle  output  1  high in IDLE with the FIFO empty
- finished  output  1  high in FINISHED
- issued_cnt  output  8  count of commands issued; saturates at 255

## Operation
- Reset values: full=0, level=0, overflow=0, bad_cmd=0, lcd_cmd=0, lcd_cmd_valid=0, seq_idle=0, finished=0, issued_cnt=0. FIFO pointers are 0 and the state is INIT.
- FIFO:
  - push with !full writes push_cmd at the write pointer; pointers wrap modulo DEPTH.
  - push while full is dropped and sets overflow. This holds even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle leave level unchanged.
- Valid codes are 0..12. Codes 13..15 are discarded in IDLE: pop, set bad_cmd, no issue, no count, stay in IDLE.
- States:
  - INIT: wait for the controller to finish its post-reset image load. Go to IDLE on the first cycle after reset with lcd_busy=0.
  - IDLE: if the FIFO is non-empty and lcd_busy=0:
    - head is a valid code: pop it, load lcd_cmd=head, set lcd_cmd_valid=1, go to ISSUE.
    - head is 13..15: discard as above.
  - ISSUE (1 cycle): lcd_cmd_valid is high during this cycle. Clear valid, increment issued_cnt (saturating), go to GUARD.
  - GUARD (1 cycle): ignore lcd_busy. If lcd_cmd=0, go to WAIT_DONE; otherwise go to WAIT.
  - WAIT: stay until lcd_busy=0, then go to IDLE.
  - WAIT_DONE: stay until lcd_done=1, then go to FINISHED.
  - FINISHED: terminal. No further pops or issues. The FIFO still accepts pushes. Only reset exits this state.
- lcd_cmd holds its last value outside ISSUE.
- Asynchronous reset mid-operation: the FIFO contents are discarded, all outputs return to their reset values immediately, and the state returns to INIT.

## Timing
- Issue latency: push at edge N into an empty FIFO, with the sequencer in IDLE and lcd_busy=0:
  - lcd_cmd_valid is high from edge N+2 to edge N+3.
  - level shows 1 after edge N and 0 after edge N+2.
- Back-to-back commands with lcd_busy held 0: consecutive rising edges of lcd_cmd_valid are at least 4 cycles apart (IDLE, ISSUE, GUARD, WAIT).
- lcd_busy is sampled only in INIT, IDLE and WAIT.
- lcd_done is sampled only in WAIT_DONE. A done pulse of one cycle is sufficient.
- lcd_cmd_valid is never high for more than one consecutive cycle.
- Outputs are glitch-free because all of them are registered; full, level and seq_idle are derived from registered pointers.

## Test plan
- Reset, hold lcd_busy=1 for 70 cycles, push 3 -> no lcd_cmd_valid while busy. Exactly one issue of lcd_cmd=3 occurs 2 cycles after lcd_busy falls; issued_cnt=1.
- With lcd_busy=0, push 1, 5, 9 on consecutive cycles -> issues occur in order 1, 5, 9, each a one-cycle strobe, with rising edges exactly 4 cycles apart; then seq_idle=1 and level=0.
- Push 8 (DEPTH) commands while lcd_busy=1 after INIT, then push once more -> full=1, level=8, overflow=1, and the ninth command is never issued.
- Push 14, then 2 -> bad_cmd=1, only lcd_cmd=2 is issued, issued_cnt=1.
- Push 0, then 4; pulse lcd_done 10 cycles after the Write issue -> finished=1, command 4 remains in the FIFO (level=1) and is never issued.
- Assert reset during WAIT with 3 entries queued -> all outputs return to reset values asynchronously and level=0. After release, no issue occurs until lcd_busy=0 is sampled.

Source files
------------

// File: rtl/lcd_cmd_sequencer_if.sv
// Host-side FIFO push port and display-controller command port of the sequencer.
// The slave modport is the sequencer. The master modport is the host/controller side.
interface lcd_cmd_sequencer_if #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
);
    logic          push;
    logic [3:0]    push_cmd;
    logic          full;
    logic [AW:0]   level;
    logic          overflow;
    logic          bad_cmd;
    logic          lcd_busy;
    logic          lcd_done;
    logic [3:0]    lcd_cmd;
    logic          lcd_cmd_valid;
    logic          seq_idle;
    logic          finished;
    logic [7:0]    issued_cnt;

    modport master (
        output push, push_cmd, lcd_busy, lcd_done,
        input  full, level, overflow, bad_cmd, lcd_cmd, lcd_cmd_valid,
               seq_idle, finished, issued_cnt
    );

    modport slave (
        input  push, push_cmd, lcd_busy, lcd_done,
        output full, level, overflow, bad_cmd, lcd_cmd, lcd_cmd_valid,
               seq_idle, finished, issued_cnt
    );
endinterface

// File: rtl/lcd_cmd_sequencer.sv
// Queues 4-bit display commands and issues them one at a time to the display
// controller when it is not busy. Stops for good after the Write command (0) completes.
module lcd_cmd_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    lcd_cmd_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        ST_INIT, ST_IDLE, ST_ISSUE, ST_GUARD, ST_WAIT, ST_WAIT_DONE, ST_FINISHED
    } state_t;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    level_q, level_d;
    logic [3:0]     mem_q [DEPTH];
    logic [3:0]     head_q, head_d;
    logic           head_vld_q, head_vld_d;
    logic           overflow_q, overflow_d;
    logic           bad_cmd_q, bad_cmd_d;
    logic [3:0]     lcd_cmd_q, lcd_cmd_d;
    logic           lcd_cmd_valid_q, lcd_cmd_valid_d;
    logic [7:0]     issued_cnt_q, issued_cnt_d;
    logic           full, push_ok, pop;

    assign full    = (level_q == FULL_LVL);
    assign push_ok = bus.push && !full;

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        level_d         = level_q;
        overflow_d      = overflow_q;
        bad_cmd_d       = bad_cmd_q;
        lcd_cmd_d       = lcd_cmd_q;
        lcd_cmd_valid_d = 1'b0;
        issued_cnt_d    = issued_cnt_q;
        pop             = 1'b0;

        unique case (state_q)
            ST_INIT:      if (!bus.lcd_busy) state_d = ST_IDLE;
            ST_IDLE: begin
                if (head_vld_q && !bus.lcd_busy) begin
                    pop = 1'b1;
                    if (head_q <= 4'd12) begin
                        lcd_cmd_d       = head_q;
                        lcd_cmd_valid_d = 1'b1;
                        state_d         = ST_ISSUE;
                    end else begin
                        bad_cmd_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (issued_cnt_q != 8'hFF) issued_cnt_d = issued_cnt_q + 8'd1;
                state_d = ST_GUARD;
            end
            ST_GUARD:     state_d = (lcd_cmd_q == 4'd0) ? ST_WAIT_DONE : ST_WAIT;
            ST_WAIT:      if (!bus.lcd_busy) state_d = ST_IDLE;
            ST_WAIT_DONE: if (bus.lcd_done) state_d = ST_FINISHED;
            ST_FINISHED:  state_d = ST_FINISHED;
            default:      state_d = ST_INIT;
        endcase

        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push_ok, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
        if (bus.push && full) overflow_d = 1'b1;

        // Head is re-registered every cycle; it is stale for one cycle after a pop.
        head_d     = mem_q[rd_ptr_q];
        head_vld_d = (level_q != '0) && !pop;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.push_cmd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_INIT;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            head_q          <= '0;
            head_vld_q      <= 1'b0;
            overflow_q      <= 1'b0;
            bad_cmd_q       <= 1'b0;
            lcd_cmd_q       <= '0;
            lcd_cmd_valid_q <= 1'b0;
            issued_cnt_q    <= '0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            head_q          <= head_d;
            head_vld_q      <= head_vld_d;
            overflow_q      <= overflow_d;
            bad_cmd_q       <= bad_cmd_d;
            lcd_cmd_q       <= lcd_cmd_d;
            lcd_cmd_valid_q <= lcd_cmd_valid_d;
            issued_cnt_q    <= issued_cnt_d;
        end
    end

    assign bus.full          = full;
    assign bus.level         = level_q;
    assign bus.overflow      = overflow_q;
    assign bus.bad_cmd       = bad_cmd_q;
    assign bus.lcd_cmd       = lcd_cmd_q;
    assign bus.lcd_cmd_valid = lcd_cmd_valid_q;
    assign bus.seq_idle      = (state_q == ST_IDLE) && (level_q == '0);
    assign bus.finished      = (state_q == ST_FINISHED);
    assign bus.issued_cnt    = issued_cnt_q;
endmodule
